// File: rtl/booth_accum.sv
// booth_accum
//   Accumulates groups of TERMS signed products from a sequential Booth
//   multiplier and presents each completed sum on a valid/ready output.
//   The block owns the multiplier's enable so that a stalled output side
//   throttles the multiplier rather than losing products.
//
// Parameters
//   WIDTH  multiplier operand width (product is 2*WIDTH bits, signed)
//   TERMS  products per group, 2..256
//   ACC_W  accumulator / output width, >= 2*WIDTH
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   prod_valid  multiplier done pulse
//   prod        signed product from the multiplier
//   clear       synchronous abort of the group in progress
//   mult_en     multiplier enable (low while stalled)
//   acc_valid   acc_data holds a completed sum
//   acc_data    completed signed sum
//   out_ready   downstream accepts acc_data
//   drop        sticky: a product arrived while stalled
//   sat         sticky: an add saturated (only with ACC_SAT_EN)
//
// Build option
//   ACC_SAT_EN  when defined, every add saturates to the ACC_W-bit signed
//               range and the sticky sat port exists; otherwise adds wrap.

module booth_accum #(
    parameter int WIDTH = 8,
    parameter int TERMS = 4,
    parameter int ACC_W = 2*WIDTH+4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prod_valid,
    input  logic [2*WIDTH-1:0] prod,
    input  logic               clear,
    output logic               mult_en,
    output logic               acc_valid,
    output logic [ACC_W-1:0]   acc_data,
    input  logic               out_ready,
    output logic               drop
`ifdef ACC_SAT_EN
    ,
    output logic               sat
`endif
);

    localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMS-1);

    typedef enum logic {
        RUN,
        STALL
    } state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        cnt;
    logic [ACC_W-1:0]        obuf;
    logic                    xfer;

    // Sign-extend the product to the accumulator width.
    assign prod_ext = ACC_W'($signed(prod));

    assign xfer     = acc_valid && out_ready;
    assign mult_en  = (state == RUN);
    assign acc_data = obuf;

`ifdef ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_wide;
    logic                  ovf;

    // One guard bit: overflow shows up as the top two bits disagreeing,
    // and the guard bit then gives the direction to clamp towards.
    always_comb begin
        sum_wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
        ovf      = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        if (!ovf) begin
            sum = sum_wide[ACC_W-1:0];
        end else if (sum_wide[ACC_W]) begin
            sum = SAT_MIN;
        end else begin
            sum = SAT_MAX;
        end
    end
`else
    assign sum = acc + prod_ext;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            acc       <= '0;
            cnt       <= '0;
            obuf      <= '0;
            acc_valid <= 1'b0;
            drop      <= 1'b0;
`ifdef ACC_SAT_EN
            sat       <= 1'b0;
`endif
        end else begin
            // A transfer empties the slot unless a load below refills it.
            if (xfer) begin
                acc_valid <= 1'b0;
            end

            if (clear) begin
                // Group state is discarded; the output slot and any
                // transfer this cycle carry on untouched.
                acc   <= '0;
                cnt   <= '0;
                state <= RUN;
                drop  <= 1'b0;
`ifdef ACC_SAT_EN
                sat   <= 1'b0;
`endif
            end else begin
                case (state)
                    RUN: begin
                        if (prod_valid) begin
`ifdef ACC_SAT_EN
                            if (ovf) begin
                                sat <= 1'b1;
                            end
`endif
                            if (cnt == LAST) begin
                                cnt <= '0;
                                if (!acc_valid || xfer) begin
                                    obuf      <= sum;
                                    acc_valid <= 1'b1;
                                    acc       <= '0;
                                end else begin
                                    // Slot still occupied: park the sum
                                    // in acc and hold off the multiplier.
                                    acc   <= sum;
                                    state <= STALL;
                                end
                            end else begin
                                acc <= sum;
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end

                    STALL: begin
                        if (prod_valid) begin
                            drop <= 1'b1;
                        end
                        if (xfer) begin
                            obuf      <= acc;
                            acc_valid <= 1'b1;
                            acc       <= '0;
                            state     <= RUN;
                        end
                    end

                    default: begin
                        state <= RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_booth_accum.sv
// Self-checking bench for booth_accum: a table of per-cycle vectors with
// hand-computed expected outputs, followed by hand-written reset and
// saturation sequences. Builds with or without ACC_SAT_EN.

module tb_booth_accum;

    logic        clk;
    logic        rst_n;
    logic        prod_valid;
    logic [15:0] prod;
    logic        clear;
    logic        mult_en;
    logic        acc_valid;
    logic [19:0] acc_data;
    logic        out_ready;
    logic        drop;

    logic        prod_valid16;
    logic [15:0] prod16;
    logic        clear16;
    logic        mult_en16;
    logic        acc_valid16;
    logic [15:0] acc_data16;
    logic        out_ready16;
    logic        drop16;

`ifdef ACC_SAT_EN
    logic        sat;
    logic        sat16;
`endif

    int checks;
    int failures;

    booth_accum #(.WIDTH(8), .TERMS(4), .ACC_W(20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_valid (prod_valid),
        .prod       (prod),
        .clear      (clear),
        .mult_en    (mult_en),
        .acc_valid  (acc_valid),
        .acc_data   (acc_data),
        .out_ready  (out_ready),
        .drop       (drop)
`ifdef ACC_SAT_EN
        ,
        .sat        (sat)
`endif
    );

    booth_accum #(.WIDTH(8), .TERMS(4), .ACC_W(16)) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_valid (prod_valid16),
        .prod       (prod16),
        .clear      (clear16),
        .mult_en    (mult_en16),
        .acc_valid  (acc_valid16),
        .acc_data   (acc_data16),
        .out_ready  (out_ready16),
        .drop       (drop16)
`ifdef ACC_SAT_EN
        ,
        .sat        (sat16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [15:0] p;
        logic        clr;
        logic        rdy;
        logic        en;
        logic        av;
        logic [19:0] d;
        logic        drp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int pv, input int p, input int clr, input int rdy,
                       input int en, input int av, input int d, input int drp);
        vec_t v;
        v.pv  = 1'(pv);
        v.p   = 16'(p);
        v.clr = 1'(clr);
        v.rdy = 1'(rdy);
        v.en  = 1'(en);
        v.av  = 1'(av);
        v.d   = 20'(d);
        v.drp = 1'(drp);
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_main();
        prod_valid = 1'b0;
        prod       = '0;
        clear      = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        idle_main();
        out_ready    = 1'b1;
        prod_valid16 = 1'b0;
        prod16       = '0;
        clear16      = 1'b0;
        out_ready16  = 1'b1;

        step();
        step();
        check("reset mult_en",   32'(mult_en),   32'd1);
        check("reset acc_valid", 32'(acc_valid), 32'd0);
        check("reset acc_data",  32'(acc_data),  32'd0);
        check("reset drop",      32'(drop),      32'd0);
        rst_n = 1'b1;

        //   pv  prod   clr rdy  en av data      drop
        // basic group
        add(1, 15,     0, 1,  1, 0, 0,        0);
        add(1, -14,    0, 1,  1, 0, 0,        0);
        add(1, 10000,  0, 1,  1, 0, 0,        0);
        add(1, 16384,  0, 1,  1, 1, 26385,    0);
        add(0, 0,      0, 1,  1, 0, 26385,    0);
        // back-to-back groups of 1s
        add(1, 1,      0, 1,  1, 0, 26385,    0);
        add(1, 1,      0, 1,  1, 0, 26385,    0);
        add(1, 1,      0, 1,  1, 0, 26385,    0);
        add(1, 1,      0, 1,  1, 1, 4,        0);
        add(1, 1,      0, 1,  1, 0, 4,        0);
        add(1, 1,      0, 1,  1, 0, 4,        0);
        add(1, 1,      0, 1,  1, 0, 4,        0);
        add(1, 1,      0, 1,  1, 1, 4,        0);
        add(0, 0,      0, 1,  1, 0, 4,        0);
        // backpressure: first sum held, second group stalls
        add(1, 2,      0, 0,  1, 0, 4,        0);
        add(1, 2,      0, 0,  1, 0, 4,        0);
        add(1, 2,      0, 0,  1, 0, 4,        0);
        add(1, 2,      0, 0,  1, 1, 8,        0);
        add(1, 2,      0, 0,  1, 1, 8,        0);
        add(1, 2,      0, 0,  1, 1, 8,        0);
        add(1, 2,      0, 0,  1, 1, 8,        0);
        add(1, 2,      0, 0,  0, 1, 8,        0);
        add(1, 5,      0, 0,  0, 1, 8,        1);
        add(0, 0,      0, 1,  1, 1, 8,        1);
        add(0, 0,      0, 1,  1, 0, 8,        1);
        // clear aborts a partial group and the concurrent product
        add(1, 100,    0, 1,  1, 0, 8,        1);
        add(1, 100,    0, 1,  1, 0, 8,        1);
        add(1, 7,      1, 1,  1, 0, 8,        0);
        add(1, 1,      0, 1,  1, 0, 8,        0);
        add(1, 1,      0, 1,  1, 0, 8,        0);
        add(1, 1,      0, 1,  1, 0, 8,        0);
        add(1, 1,      0, 1,  1, 1, 4,        0);
        add(0, 0,      0, 1,  1, 0, 4,        0);
        // final term together with a transfer: no stall, valid stays high
        add(1, 3,      0, 0,  1, 0, 4,        0);
        add(1, 3,      0, 0,  1, 0, 4,        0);
        add(1, 3,      0, 0,  1, 0, 4,        0);
        add(1, 3,      0, 0,  1, 1, 12,       0);
        add(1, 5,      0, 0,  1, 1, 12,       0);
        add(1, 5,      0, 0,  1, 1, 12,       0);
        add(1, 5,      0, 0,  1, 1, 12,       0);
        add(1, 5,      0, 1,  1, 1, 20,       0);
        add(0, 0,      0, 1,  1, 0, 20,       0);
        // negative products sign-extend: 4 * -32768 = -131072
        add(1, -32768, 0, 1,  1, 0, 20,       0);
        add(1, -32768, 0, 1,  1, 0, 20,       0);
        add(1, -32768, 0, 1,  1, 0, 20,       0);
        add(1, -32768, 0, 1,  1, 1, 'hE0000,  0);
        add(0, 0,      0, 1,  1, 0, 'hE0000,  0);

        foreach (vq[i]) begin
            prod_valid = vq[i].pv;
            prod       = vq[i].p;
            clear      = vq[i].clr;
            out_ready  = vq[i].rdy;
            step();
            check($sformatf("vec%0d mult_en", i),   32'(mult_en),   32'(vq[i].en));
            check($sformatf("vec%0d acc_valid", i), 32'(acc_valid), 32'(vq[i].av));
            check($sformatf("vec%0d acc_data", i),  32'(acc_data),  32'(vq[i].d));
            check($sformatf("vec%0d drop", i),      32'(drop),      32'(vq[i].drp));
        end
        idle_main();

`ifdef ACC_SAT_EN
        check("no sat in normal range", 32'(sat), 32'd0);
`endif

        // Reset mid-group: partial sum lost, outputs cleared.
        out_ready  = 1'b1;
        prod_valid = 1'b1;
        prod       = 16'd50;
        step();
        step();
        prod_valid = 1'b0;
        rst_n      = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst mid mult_en",   32'(mult_en),   32'd1);
        check("rst mid acc_valid", 32'(acc_valid), 32'd0);
        check("rst mid acc_data",  32'(acc_data),  32'd0);
        check("rst mid drop",      32'(drop),      32'd0);
        prod_valid = 1'b1;
        prod       = 16'd1;
        for (int k = 0; k < 4; k++) step();
        prod_valid = 1'b0;
        check("post rst acc_valid", 32'(acc_valid), 32'd1);
        check("post rst acc_data",  32'(acc_data),  32'd4);
        step();

        // Reset while stalled with drop set.
        out_ready  = 1'b0;
        prod_valid = 1'b1;
        prod       = 16'd2;
        for (int k = 0; k < 8; k++) step();
        check("stall mult_en", 32'(mult_en), 32'd0);
        step();
        check("stall drop", 32'(drop), 32'd1);
        prod_valid = 1'b0;
        rst_n      = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst stall mult_en",   32'(mult_en),   32'd1);
        check("rst stall acc_valid", 32'(acc_valid), 32'd0);
        check("rst stall acc_data",  32'(acc_data),  32'd0);
        check("rst stall drop",      32'(drop),      32'd0);
        out_ready = 1'b1;

        // 16-bit accumulator: 16384 + 16384 overflows.
        out_ready16  = 1'b1;
        prod_valid16 = 1'b1;
        prod16 = 16'd16384;
        step();
        step();
        prod16 = 16'hFFFF;
        step();
        prod16 = 16'd0;
        step();
        prod_valid16 = 1'b0;
        check("sat16 acc_valid", 32'(acc_valid16), 32'd1);
`ifdef ACC_SAT_EN
        check("sat16 acc_data", 32'(acc_data16), 32'h7FFE);
        check("sat16 sat",      32'(sat16),      32'd1);
        clear16 = 1'b1;
        step();
        clear16 = 1'b0;
        check("sat16 clear sat", 32'(sat16), 32'd0);
`else
        check("wrap16 acc_data", 32'(acc_data16), 32'h7FFF);
        step();
`endif
        check("sat16 mult_en", 32'(mult_en16), 32'd1);
        check("sat16 drop",    32'(drop16),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_accum.md
# booth_accum

Downstream consumer for the sequential Booth multiplier. It captures each signed product on the multiplier's one-cycle `done` pulse and sums groups of `TERMS` products into a wider accumulator. Completed sums go out through a valid/ready port. The block drives the multiplier's `en` input, so it throttles the multiplier instead of losing products when the output side stalls. Used as the accumulate half of the dot-product path.

## Interface
- `WIDTH`, 8: multiplier operand width; the product is `2*WIDTH` bits, signed.
- `TERMS`, 4: products per group; legal range is 2 to 256.
- `ACC_W`, `2*WIDTH+4`: accumulator and output width; must be at least `2*WIDTH`.

- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `prod_valid` input 1: multiplier `done` pulse.
- `prod` input `2*WIDTH`: multiplier `M`, signed.
- `clear` input 1: synchronous abort of the group in progress.
- `mult_en` output 1: drives multiplier `en`.
- `acc_valid` output 1: output register holds a completed sum.
- `acc_data` output `ACC_W`: completed sum, signed.
- `out_ready` input 1: downstream accepts `acc_data`.
- `drop` output 1: sticky; a product arrived while in STALL.
- `sat` output 1: sticky; saturation occurred. Exists only with `ACC_SAT_EN`.

## Operation
- Internal state: accumulator `acc` (`ACC_W` bits), term counter `cnt` (0 to `TERMS-1`), output register `obuf`, FSM state in {RUN, STALL}.
- Sign extension: `prod` is sign-extended to `ACC_W` before every add.
- RUN, with `prod_valid` and `cnt < TERMS-1`:
  - `acc <= acc + prod`
  - `cnt <= cnt + 1`
- RUN, with `prod_valid` and `cnt == TERMS-1` (final term; `sum = acc + prod`):
  - If the output slot is free, meaning `!acc_valid`, or `acc_valid && out_ready` this cycle: `obuf <= sum`, `acc_valid <= 1`, `acc <= 0`, `cnt <= 0`; stay in RUN.
  - Otherwise: `acc <= sum`, `cnt <= 0`, go to STALL.
- STALL:
  - `mult_en = 0`; in RUN, `mult_en = 1`.
  - Any `prod_valid` in STALL sets `drop` and is discarded.
  - On `acc_valid && out_ready`: `obuf <= acc`, `acc_valid` stays 1, `acc <= 0`, go to RUN.
- Output handshake:
  - Transfer occurs when `acc_valid && out_ready`.
  - `acc_data` is held stable while `acc_valid && !out_ready`.
  - On a transfer with no new load, `acc_valid <= 0` next cycle.
- `clear`:
  - Priority over `prod_valid` and over the STALL reload.
  - Effect: `acc <= 0`, `cnt <= 0`, state to RUN, `drop <= 0`, `sat <= 0`.
  - `obuf`, `acc_valid` and any transfer in the same cycle are unaffected.
- Reset (`rst_n` low at an edge), mid-operation included:
  - Contents: `acc`, `cnt`, `obuf` to 0.
  - FSM: state to RUN.
  - Outputs: `acc_valid = 0`, `acc_data = 0`, `drop = 0`, `sat = 0`.
  - Any partial group is lost.

## Timing
- `mult_en` is combinational from state, so it drops in the same cycle STALL is entered (the cycle after the final term's `prod_valid`).
- Latency: `acc_valid` rises 1 cycle after the final term's `prod_valid`.
- STALL exit: one cycle after the transfer, `acc_data` shows the stalled sum and `mult_en` is 1.
- Final term and transfer in the same cycle: back-to-back results, with `acc_valid` held high.
- `prod_valid` on consecutive cycles is accepted in RUN; there is no minimum spacing.
- Throughput: one product per cycle in RUN.

## Configuration
- Macro: `ACC_SAT_EN`.
- Defined:
  - Each add saturates to the `ACC_W`-bit signed maximum or minimum (`2^(ACC_W-1)-1` or `-2^(ACC_W-1)`).
  - Saturation sets sticky `sat`.
  - Later adds continue from the saturated value.
- Undefined:
  - Adds wrap modulo `2^ACC_W`.
  - The `sat` port is absent.

## Test plan
- Basic group, with `WIDTH=8`, `TERMS=4`, `ACC_W=20`:
  - Stimulus: products 15, -14, 10000, 16384 arrive, `out_ready=1`.
  - Response: `acc_data=26385` (0x06711) and `acc_valid` high for 1 cycle, 1 cycle after the last product.
- Back-to-back groups:
  - Stimulus: 8 consecutive `prod_valid` of 1, `out_ready=1`.
  - Response: two results of 4, and `mult_en` never drops.
- Backpressure:
  - Stimulus: `out_ready=0`, 8 products of 2.
  - Response: after the first group, `acc_data=8` held; after the second group, STALL and `mult_en=0`.
  - A `prod_valid` injected in STALL sets `drop=1`.
  - Then raising `out_ready` gives sum 8, then sum 8, then `mult_en=1`.
- Clear:
  - Stimulus: 2 products of 100, then `clear` together with a third `prod_valid`.
  - Response: the third product is ignored, `cnt=0`, and the next 4 products of 1 give 4.
- Reset mid-group and in STALL:
  - Stimulus: assert `rst_n=0` for 1 cycle.
  - Response: all outputs 0 and `mult_en=1` after the edge.
- Saturation, with `ACC_SAT_EN` and `ACC_W=16`:
  - Stimulus: products 16384, 16384, -1, 0.
  - Response: `acc_data=32766` (0x7FFE) and `sat=1`.
  - Without the macro, the same stimulus gives `acc_data=-32769` mod 2^16, i.e. 0x7FFF.
